// File: rtl/ctrl_pila_pkg.sv
// Shared widths, select codes, state encoding and vector helper for the stack controller.
package ctrl_pila_pkg;

    localparam int unsigned ANCHO   = 10;
    localparam int unsigned PROF    = 16;
    localparam int unsigned NINT    = 4;
    localparam int unsigned NIVEL_W = $clog2(PROF) + 1;
    localparam int unsigned IDX_W   = (NINT > 1) ? $clog2(NINT) : 1;

    localparam logic [ANCHO-1:0]   VECT_BASE = 10'h3C0;
    localparam logic [NIVEL_W-1:0] PROF_N    = NIVEL_W'(PROF);

    localparam logic [1:0] SEL_NORMAL = 2'b00;
    localparam logic [1:0] SEL_PILA   = 2'b01;
    localparam logic [1:0] SEL_VECT   = 2'b10;

    typedef enum logic {
        NORMAL   = 1'b0,
        SERVICIO = 1'b1
    } estado_t;

    // Vector i sits at VECT_BASE + 4*i.
    function automatic logic [ANCHO-1:0] dir_vector(input logic [IDX_W-1:0] idx);
        return VECT_BASE + ANCHO'({idx, 2'b00});
    endfunction

endpackage

// File: rtl/ctrl_pila_if.sv
// Decoded-instruction / interrupt inputs and stack/PC control outputs of the controller.
interface ctrl_pila_if;
    import ctrl_pila_pkg::*;

    logic               call;
    logic               ret;
    logic               reti;
    logic               ei;
    logic               di;
    logic [ANCHO-1:0]   pc_act;
    logic [ANCHO-1:0]   pc_sig;
    logic [NINT-1:0]    int_req;

    logic               push;
    logic               pop;
    logic               weSP;
    logic [ANCHO-1:0]   dato_pila;
    logic [1:0]         sel_pc;
    logic [ANCHO-1:0]   vector;
    logic               anular;
    logic [NINT-1:0]    int_ack;
    logic               en_servicio;
    logic [NIVEL_W-1:0] nivel;
    logic               desb;
    logic               vacio_err;

    modport master (
        output call, ret, reti, ei, di, pc_act, pc_sig, int_req,
        input  push, pop, weSP, dato_pila, sel_pc, vector, anular, int_ack,
               en_servicio, nivel, desb, vacio_err
    );

    modport slave (
        input  call, ret, reti, ei, di, pc_act, pc_sig, int_req,
        output push, pop, weSP, dato_pila, sel_pc, vector, anular, int_ack,
               en_servicio, nivel, desb, vacio_err
    );

endinterface

// File: rtl/ctrl_pila_prio_int.sv
// Fixed-priority encoder: the lowest-numbered pending line wins.
module prio_int
    import ctrl_pila_pkg::*;
#(
    parameter int unsigned N   = NINT,
    parameter int unsigned IDX = IDX_W
) (
    input  logic [N-1:0]   pend,
    output logic           valid,
    output logic [N-1:0]   grant,
    output logic [IDX-1:0] idx
);

    // Isolate the lowest set bit and encode its position.
    always_comb begin
        valid = |pend;
        grant = pend & (~pend + N'(1));
        idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant[i]) begin
                idx = IDX'(i);
            end
        end
    end

endmodule

// File: rtl/ctrl_pila.sv
// Return-address stack controller: call/ret/reti sequencing, interrupt entry and depth tracking.
module ctrl_pila
    import ctrl_pila_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    ctrl_pila_if.slave  bus
);

    estado_t            estado, estado_n;
    logic [NIVEL_W-1:0] nivel, nivel_n;
    logic [NINT-1:0]    pend, pend_n;
    logic               int_en, int_en_n;
    logic               desb, desb_n;
    logic               vacio, vacio_n;

    logic               pend_valid;
    logic [NINT-1:0]    grant;
    logic [IDX_W-1:0]   idx;
    logic               tomar;
    logic               hay_espacio;
    logic               hay_datos;

    prio_int #(.N(NINT), .IDX(IDX_W)) u_prio (
        .pend  (pend),
        .valid (pend_valid),
        .grant (grant),
        .idx   (idx)
    );

    assign hay_espacio = (nivel < PROF_N);
    assign hay_datos   = (nivel != '0);

    // Interrupt entry only in an idle NORMAL cycle with room on the stack.
    assign tomar = (estado == NORMAL) && int_en && pend_valid &&
                   !bus.call && !bus.ret && !bus.reti && hay_espacio;

    // State, depth, pending latch, enable and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= NORMAL;
            nivel  <= '0;
            pend   <= '0;
            int_en <= 1'b0;
            desb   <= 1'b0;
            vacio  <= 1'b0;
        end else begin
            estado <= estado_n;
            nivel  <= nivel_n;
            pend   <= pend_n;
            int_en <= int_en_n;
            desb   <= desb_n;
            vacio  <= vacio_n;
        end
    end

    // Next-state and same-cycle stack/PC controls; interrupt > call > ret/reti.
    always_comb begin
        estado_n      = estado;
        nivel_n       = nivel;
        desb_n        = desb;
        vacio_n       = vacio;
        int_en_n      = bus.di ? 1'b0 : (bus.ei ? 1'b1 : int_en);
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.weSP      = 1'b0;
        bus.dato_pila = bus.pc_sig;
        bus.sel_pc    = SEL_NORMAL;
        bus.vector    = '0;
        bus.anular    = 1'b0;
        bus.int_ack   = '0;

        if (tomar) begin
            bus.push      = 1'b1;
            bus.weSP      = 1'b1;
            bus.dato_pila = bus.pc_act;
            bus.sel_pc    = SEL_VECT;
            bus.vector    = dir_vector(idx);
            bus.anular    = 1'b1;
            bus.int_ack   = grant;
            nivel_n       = nivel + NIVEL_W'(1);
            estado_n      = SERVICIO;
        end else if (bus.call) begin
            if (hay_espacio) begin
                bus.push = 1'b1;
                bus.weSP = 1'b1;
                nivel_n  = nivel + NIVEL_W'(1);
            end else begin
                desb_n = 1'b1;
            end
        end else if (bus.ret || bus.reti) begin
            if (hay_datos) begin
                bus.pop    = 1'b1;
                bus.weSP   = 1'b1;
                bus.sel_pc = SEL_PILA;
                nivel_n    = nivel - NIVEL_W'(1);
            end else begin
                vacio_n = 1'b1;
            end
            // reti leaves the ISR even when the pop underflows.
            if (bus.reti && (estado == SERVICIO)) begin
                estado_n = NORMAL;
            end
        end

        // Acknowledge clears its line and beats a same-cycle request.
        pend_n = (pend | bus.int_req) & ~bus.int_ack;
    end

    // Registered state straight to the outputs.
    assign bus.en_servicio = (estado == SERVICIO);
    assign bus.nivel       = nivel;
    assign bus.desb        = desb;
    assign bus.vacio_err   = vacio;

endmodule

// File: tb/tb_ctrl_pila.sv
// Directed scoreboard bench for ctrl_pila: driver queues expected outputs, monitor compares per cycle.
module tb_ctrl_pila;
    import ctrl_pila_pkg::*;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic       we;
        logic [9:0] dato;
        logic [1:0] sel;
        logic [9:0] vec;
        logic       anu;
        logic [3:0] ack;
        logic       srv;
        logic [4:0] niv;
        logic       desb;
        logic       vac;
    } exp_t;

    typedef struct {
        string nm;
        exp_t  v;
    } sb_t;

    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_CALL = 5'b10000;
    localparam logic [4:0] OP_RET  = 5'b01000;
    localparam logic [4:0] OP_RETI = 5'b00100;
    localparam logic [4:0] OP_EI   = 5'b00010;
    localparam logic [4:0] OP_DI   = 5'b00001;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    sb_t  sb[$];

    always #5 clk = ~clk;

    ctrl_pila_if bus ();

    ctrl_pila dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic exp_t x_idle(input logic [9:0] ps, input logic srv,
                                    input logic [4:0] niv, input logic dsb, input logic vac);
        exp_t e;
        e      = '0;
        e.dato = ps;
        e.srv  = srv;
        e.niv  = niv;
        e.desb = dsb;
        e.vac  = vac;
        return e;
    endfunction

    function automatic exp_t x_push(input logic [9:0] ps, input logic srv,
                                    input logic [4:0] niv, input logic dsb, input logic vac);
        exp_t e;
        e      = x_idle(ps, srv, niv, dsb, vac);
        e.push = 1'b1;
        e.we   = 1'b1;
        return e;
    endfunction

    function automatic exp_t x_pop(input logic [9:0] ps, input logic srv,
                                   input logic [4:0] niv, input logic dsb, input logic vac);
        exp_t e;
        e     = x_idle(ps, srv, niv, dsb, vac);
        e.pop = 1'b1;
        e.we  = 1'b1;
        e.sel = 2'b01;
        return e;
    endfunction

    function automatic exp_t x_take(input logic [9:0] pa, input logic [3:0] ack, input logic [9:0] vec,
                                    input logic [4:0] niv, input logic dsb, input logic vac);
        exp_t e;
        e      = x_idle(pa, 1'b0, niv, dsb, vac);
        e.push = 1'b1;
        e.we   = 1'b1;
        e.sel  = 2'b10;
        e.vec  = vec;
        e.anu  = 1'b1;
        e.ack  = ack;
        return e;
    endfunction

    // Drive one cycle of inputs just after the edge and queue what the DUT must show.
    task automatic step(input string nm, input logic [4:0] op, input logic [9:0] pa,
                        input logic [9:0] ps, input logic [3:0] rq, input exp_t ex);
        sb_t s;
        @(posedge clk);
        #1;
        reset = 1'b0;
        {bus.call, bus.ret, bus.reti, bus.ei, bus.di} = op;
        bus.pc_act  = pa;
        bus.pc_sig  = ps;
        bus.int_req = rq;
        s.nm = nm;
        s.v  = ex;
        sb.push_back(s);
    endtask

    // Assert reset mid-cycle, away from any edge, and queue the cleared outputs.
    task automatic rst_step(input string nm, input logic [9:0] ps, input exp_t ex);
        sb_t s;
        @(posedge clk);
        #1;
        {bus.call, bus.ret, bus.reti, bus.ei, bus.di} = OP_NONE;
        bus.pc_act  = '0;
        bus.pc_sig  = ps;
        bus.int_req = '0;
        #1;
        reset = 1'b1;
        s.nm = nm;
        s.v  = ex;
        sb.push_back(s);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation each cycle.
    initial begin
        sb_t  e;
        exp_t g;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e      = sb.pop_front();
                g.push = bus.push;
                g.pop  = bus.pop;
                g.we   = bus.weSP;
                g.dato = bus.dato_pila;
                g.sel  = bus.sel_pc;
                g.vec  = bus.vector;
                g.anu  = bus.anular;
                g.ack  = bus.int_ack;
                g.srv  = bus.en_servicio;
                g.niv  = bus.nivel;
                g.desb = bus.desb;
                g.vac  = bus.vacio_err;
                n_vec++;
                if (g !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got push=%b pop=%b we=%b dato=%h sel=%b vec=%h anu=%b ack=%b srv=%b niv=%0d desb=%b vac=%b | want push=%b pop=%b we=%b dato=%h sel=%b vec=%h anu=%b ack=%b srv=%b niv=%0d desb=%b vac=%b",
                             e.nm, g.push, g.pop, g.we, g.dato, g.sel, g.vec, g.anu, g.ack, g.srv, g.niv, g.desb, g.vac,
                             e.v.push, e.v.pop, e.v.we, e.v.dato, e.v.sel, e.v.vec, e.v.anu, e.v.ack, e.v.srv, e.v.niv, e.v.desb, e.v.vac);
                end
            end
        end
    end

    initial begin
        {bus.call, bus.ret, bus.reti, bus.ei, bus.di} = OP_NONE;
        bus.pc_act  = '0;
        bus.pc_sig  = '0;
        bus.int_req = '0;

        rst_step("rst_init", 10'h000, x_idle(10'h000, 1'b0, 5'd0, 1'b0, 1'b0));

        // Plain call/ret and simultaneous-instruction priority.
        step("t1_call",     OP_CALL,           10'h020, 10'h021, 4'h0, x_push(10'h021, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t1_ret",      OP_RET,            10'h030, 10'h022, 4'h0, x_pop (10'h022, 1'b0, 5'd1, 1'b0, 1'b0));
        step("t1_idle",     OP_NONE,           10'h000, 10'h023, 4'h0, x_idle(10'h023, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t1_callret",  OP_CALL | OP_RET,  10'h000, 10'h031, 4'h0, x_push(10'h031, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t1_callreti", OP_CALL | OP_RETI, 10'h000, 10'h032, 4'h0, x_push(10'h032, 1'b0, 5'd1, 1'b0, 1'b0));
        step("t1_ret2",     OP_RET,            10'h000, 10'h033, 4'h0, x_pop (10'h033, 1'b0, 5'd2, 1'b0, 1'b0));
        step("t1_ret3",     OP_RET,            10'h000, 10'h034, 4'h0, x_pop (10'h034, 1'b0, 5'd1, 1'b0, 1'b0));

        // Interrupt entry: lines 1 and 2 pending, line 1 wins.
        step("t2_ei",       OP_EI,   10'h000, 10'h040, 4'h0,    x_idle(10'h040, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t2_req",      OP_NONE, 10'h000, 10'h041, 4'b0110, x_idle(10'h041, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t2_take",     OP_NONE, 10'h050, 10'h051, 4'h0,    x_take(10'h050, 4'b0010, 10'h3C4, 5'd0, 1'b0, 1'b0));

        // Nested call/ret inside the ISR, reti back, then line 2 is taken.
        step("t3_srv_idle", OP_NONE, 10'h052, 10'h060, 4'h0, x_idle(10'h060, 1'b1, 5'd1, 1'b0, 1'b0));
        step("t3_call",     OP_CALL, 10'h000, 10'h061, 4'h0, x_push(10'h061, 1'b1, 5'd1, 1'b0, 1'b0));
        step("t3_ret",      OP_RET,  10'h000, 10'h062, 4'h0, x_pop (10'h062, 1'b1, 5'd2, 1'b0, 1'b0));
        step("t3_reti",     OP_RETI, 10'h000, 10'h063, 4'h0, x_pop (10'h063, 1'b1, 5'd1, 1'b0, 1'b0));
        step("t3_take2",    OP_NONE, 10'h070, 10'h071, 4'h0, x_take(10'h070, 4'b0100, 10'h3C8, 5'd0, 1'b0, 1'b0));
        step("t3_reti2",    OP_RETI, 10'h000, 10'h072, 4'h0, x_pop (10'h072, 1'b1, 5'd1, 1'b0, 1'b0));

        // A call defers a pending interrupt to the next idle cycle.
        step("t4_req",      OP_NONE, 10'h000, 10'h080, 4'b0001, x_idle(10'h080, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t4_call",     OP_CALL, 10'h000, 10'h081, 4'h0,    x_push(10'h081, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t4_take",     OP_NONE, 10'h082, 10'h083, 4'h0,    x_take(10'h082, 4'b0001, 10'h3C0, 5'd1, 1'b0, 1'b0));
        step("t4_reti",     OP_RETI, 10'h000, 10'h084, 4'h0,    x_pop (10'h084, 1'b1, 5'd2, 1'b0, 1'b0));
        step("t4_ret",      OP_RET,  10'h000, 10'h085, 4'h0,    x_pop (10'h085, 1'b0, 5'd1, 1'b0, 1'b0));

        // di beats ei; a pending line stays masked.
        step("t5_eidi",     OP_EI | OP_DI, 10'h000, 10'h090, 4'h0,    x_idle(10'h090, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t5_reqm",     OP_NONE,       10'h000, 10'h091, 4'b1000, x_idle(10'h091, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t5_masked",   OP_NONE,       10'h000, 10'h092, 4'h0,    x_idle(10'h092, 1'b0, 5'd0, 1'b0, 1'b0));

        // Fill the stack, then overflow.
        for (int i = 0; i < 16; i++) begin
            step("t5_call", OP_CALL, 10'h000, 10'h100 + 10'(i), 4'h0,
                 x_push(10'h100 + 10'(i), 1'b0, 5'(i), 1'b0, 1'b0));
        end
        step("t5_ovf",      OP_CALL, 10'h000, 10'h120, 4'h0, x_idle(10'h120, 1'b0, 5'd16, 1'b0, 1'b0));
        step("t5_sticky",   OP_NONE, 10'h000, 10'h121, 4'h0, x_idle(10'h121, 1'b0, 5'd16, 1'b1, 1'b0));
        step("t5_ei",       OP_EI,   10'h000, 10'h122, 4'h0, x_idle(10'h122, 1'b0, 5'd16, 1'b1, 1'b0));
        step("t5_full",     OP_NONE, 10'h0A1, 10'h123, 4'h0, x_idle(10'h123, 1'b0, 5'd16, 1'b1, 1'b0));
        step("t5_ret",      OP_RET,  10'h000, 10'h124, 4'h0, x_pop (10'h124, 1'b0, 5'd16, 1'b1, 1'b0));
        step("t5_take",     OP_NONE, 10'h0A0, 10'h125, 4'h0, x_take(10'h0A0, 4'b1000, 10'h3CC, 5'd15, 1'b1, 1'b0));
        step("t5_req2",     OP_NONE, 10'h000, 10'h126, 4'b1000, x_idle(10'h126, 1'b1, 5'd16, 1'b1, 1'b0));
        rst_step("t5_rst",  10'h127, x_idle(10'h127, 1'b0, 5'd0, 1'b0, 1'b0));

        // After reset nothing is pending; then underflow.
        step("t6_ei",       OP_EI,   10'h000, 10'h130, 4'h0, x_idle(10'h130, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t6_nopend",   OP_NONE, 10'h000, 10'h131, 4'h0, x_idle(10'h131, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t6_unf",      OP_RET,  10'h000, 10'h132, 4'h0, x_idle(10'h132, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t6_vac",      OP_NONE, 10'h000, 10'h133, 4'h0, x_idle(10'h133, 1'b0, 5'd0, 1'b0, 1'b1));

        // Reset while in the ISR clears state, enable and errors at once.
        step("t7_req",      OP_NONE, 10'h000, 10'h140, 4'b0001, x_idle(10'h140, 1'b0, 5'd0, 1'b0, 1'b1));
        step("t7_take",     OP_NONE, 10'h141, 10'h142, 4'h0,    x_take(10'h141, 4'b0001, 10'h3C0, 5'd0, 1'b0, 1'b1));
        rst_step("t7_rst",  10'h143, x_idle(10'h143, 1'b0, 5'd0, 1'b0, 1'b0));

        // Enable came back cleared: a new request waits for ei.
        step("t8_req",      OP_NONE, 10'h000, 10'h150, 4'b0100, x_idle(10'h150, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t8_noen",     OP_NONE, 10'h000, 10'h151, 4'h0,    x_idle(10'h151, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t8_ei",       OP_EI,   10'h000, 10'h152, 4'h0,    x_idle(10'h152, 1'b0, 5'd0, 1'b0, 1'b0));
        step("t8_take",     OP_NONE, 10'h153, 10'h154, 4'h0,    x_take(10'h153, 4'b0100, 10'h3C8, 5'd0, 1'b0, 1'b0));

        repeat (3) @(posedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
